// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - streams a program into instruction memory, then releases the core from reset
module prog_loader #(
    parameter int ADDR_W        = 8,
    parameter int DEPTH         = 256,
    parameter int RELEASE_DELAY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [15:0]       in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   word_count
);

    localparam int CNT_W = (RELEASE_DELAY > 1) ? $clog2(RELEASE_DELAY) : 1;
    localparam logic [ADDR_W:0] DEPTH_C   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_ADDR = DEPTH_C - 1'b1;
    localparam logic [CNT_W-1:0] DELAY_INIT = CNT_W'(RELEASE_DELAY - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_RUN,
        S_ERROR
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  delay_q, delay_d;
    logic [ADDR_W:0]   word_count_q, word_count_d;
    logic              in_ready_q, in_ready_d;
    logic              imem_we_q, imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [15:0]       imem_wdata_q, imem_wdata_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    always_comb begin
        state_d      = state_q;
        delay_d      = delay_q;
        word_count_d = word_count_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;

        case (state_q)
            S_IDLE, S_RUN, S_ERROR: begin
                if (start) begin
                    state_d      = S_LOAD;
                    word_count_d = '0;
                end
            end
            S_LOAD: begin
                if (in_valid && in_ready_q) begin
                    imem_we_d    = 1'b1;
                    imem_addr_d  = word_count_q[ADDR_W-1:0];
                    imem_wdata_d = in_data;
                    word_count_d = (word_count_q < DEPTH_C) ? word_count_q + 1'b1 : DEPTH_C;
                    if (in_last) begin
                        state_d = S_DRAIN;
                        // The entry cycle counts as the first delay cycle.
                        delay_d = DELAY_INIT;
                    end else if (word_count_q == LAST_ADDR) begin
                        state_d = S_ERROR;
                    end
                end
            end
            S_DRAIN: begin
                if (delay_q == '0) begin
                    state_d = S_RUN;
                end else begin
                    delay_d = delay_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Status outputs are registered copies of the upcoming state.
        in_ready_d  = (state_d == S_LOAD);
        busy_d      = (state_d == S_LOAD) || (state_d == S_DRAIN);
        done_d      = (state_d == S_RUN);
        error_d     = (state_d == S_ERROR);
        cpu_reset_d = (state_d != S_RUN);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            delay_q      <= '0;
            word_count_q <= '0;
            in_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            cpu_reset_q  <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            delay_q      <= delay_d;
            word_count_q <= word_count_d;
            in_ready_q   <= in_ready_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            cpu_reset_q  <= cpu_reset_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign cpu_reset  = cpu_reset_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - directed self-checking bench for prog_loader (DEPTH 256 and DEPTH 4 instances)
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst_n, start, in_valid, in_last;
    logic [15:0] in_data;

    logic        in_ready, imem_we, cpu_reset, busy, done, error;
    logic [7:0]  imem_addr;
    logic [15:0] imem_wdata;
    logic [8:0]  word_count;

    logic        in_ready4, imem_we4, cpu_reset4, busy4, done4, error4;
    logic [1:0]  imem_addr4;
    logic [15:0] imem_wdata4;
    logic [2:0]  word_count4;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic ready_drop;

    logic [7:0]  wa[$];
    logic [15:0] wd[$];
    int          wc[$];
    logic [1:0]  wa4[$];
    logic [15:0] wd4[$];

    logic [15:0] exp_d [3] = '{16'h1234, 16'h5678, 16'h9ABC};

    always #5 clk = ~clk;

    prog_loader #(.ADDR_W(8), .DEPTH(256), .RELEASE_DELAY(2)) dut (
        .clk(clk), .reset(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .cpu_reset(cpu_reset), .busy(busy), .done(done),
        .error(error), .word_count(word_count)
    );

    prog_loader #(.ADDR_W(2), .DEPTH(4), .RELEASE_DELAY(2)) dut4 (
        .clk(clk), .reset(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(in_ready4), .imem_we(imem_we4), .imem_addr(imem_addr4),
        .imem_wdata(imem_wdata4), .cpu_reset(cpu_reset4), .busy(busy4), .done(done4),
        .error(error4), .word_count(word_count4)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (imem_we) begin
            wa.push_back(imem_addr);
            wd.push_back(imem_wdata);
            wc.push_back(cyc);
        end
        if (imem_we4) begin
            wa4.push_back(imem_addr4);
            wd4.push_back(imem_wdata4);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        wa.delete(); wd.delete(); wc.delete(); wa4.delete(); wd4.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
        tick(); tick();
        rst_n = 1'b1;
        clear_logs();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] d, input logic last, input int gap,
                             input logic sel4, output int acc);
        in_valid = 1'b0;
        for (int i = 0; i < gap; i++) begin
            if (!(sel4 ? in_ready4 : in_ready)) ready_drop = 1'b1;
            tick();
        end
        in_valid = 1'b1; in_data = d; in_last = last; acc = -1;
        for (int i = 0; i < 20 && acc < 0; i++) begin
            if (sel4 ? in_ready4 : in_ready) begin
                tick();
                acc = cyc;
            end else begin
                tick();
            end
        end
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_done(input logic sel4, output int at);
        at = -1;
        for (int i = 0; i < 30 && at < 0; i++) begin
            if (sel4 ? done4 : done) at = cyc;
            else tick();
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({cpu_reset, in_ready, imem_we, busy, done, error} !== 6'b100000) begin
            bad++; $display("FAIL reset_flags got=%b want=100000", {cpu_reset, in_ready, imem_we, busy, done, error});
        end
        total++;
        if (imem_addr !== 8'h00 || imem_wdata !== 16'h0000) begin
            bad++; $display("FAIL reset_bus got=%h/%h want=00/0000", imem_addr, imem_wdata);
        end
        total++;
        if (word_count !== 9'd0) begin
            bad++; $display("FAIL reset_count got=%0d want=0", word_count);
        end
        total++;
        if ({cpu_reset4, in_ready4, busy4, done4, error4, word_count4} !== 8'b10000000) begin
            bad++; $display("FAIL reset_dut4 got=%b want=10000000", {cpu_reset4, in_ready4, busy4, done4, error4, word_count4});
        end
    endtask

    task automatic test_basic();
        int acc[3];
        int at;
        do_reset();
        pulse_start();
        total++;
        if (in_ready !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL basic_load_entry got=%b%b want=11", in_ready, busy);
        end
        for (int i = 0; i < 3; i++) send_word(exp_d[i], i == 2, 0, 1'b0, acc[i]);
        total++;
        if (in_ready !== 1'b0) begin
            bad++; $display("FAIL basic_ready_after_last got=%b want=0", in_ready);
        end
        wait_done(1'b0, at);
        total++;
        if (at !== acc[2] + 2) begin
            bad++; $display("FAIL basic_release_cycle got=%0d want=%0d", at, acc[2] + 2);
        end
        total++;
        if (cpu_reset !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL basic_run_flags got=%b%b want=00", cpu_reset, busy);
        end
        total++;
        if (wa.size() !== 3) begin
            bad++; $display("FAIL basic_write_count got=%0d want=3", wa.size());
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (wa.size() <= i || wa[i] !== 8'(i) || wd[i] !== exp_d[i] || wc[i] !== acc[i]) begin
                bad++; $display("FAIL basic_write%0d got=%h/%h@%0d want=%h/%h@%0d", i,
                                (wa.size() > i) ? wa[i] : 8'hxx, (wd.size() > i) ? wd[i] : 16'hxxxx,
                                (wc.size() > i) ? wc[i] : -1, 8'(i), exp_d[i], acc[i]);
            end
        end
        total++;
        if (word_count !== 9'd3 || imem_addr !== 8'd2 || imem_wdata !== 16'h9ABC || imem_we !== 1'b0) begin
            bad++; $display("FAIL basic_hold got=%0d/%h/%h/%b want=3/02/9abc/0", word_count, imem_addr, imem_wdata, imem_we);
        end
        tick();
        total++;
        if (done !== 1'b1 || cpu_reset !== 1'b0) begin
            bad++; $display("FAIL basic_done_sticky got=%b%b want=10", done, cpu_reset);
        end
    endtask

    task automatic test_gaps();
        int acc;
        int at;
        int gaps[3] = '{1, 3, 2};
        do_reset();
        pulse_start();
        ready_drop = 1'b0;
        for (int i = 0; i < 3; i++) send_word(exp_d[i], i == 2, gaps[i], 1'b0, acc);
        wait_done(1'b0, at);
        total++;
        if (ready_drop !== 1'b0) begin
            bad++; $display("FAIL gaps_ready got=drop want=held");
        end
        total++;
        if (wa.size() !== 3 || at < 0) begin
            bad++; $display("FAIL gaps_write_count got=%0d/%0d want=3/done", wa.size(), at);
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (wa.size() <= i || wa[i] !== 8'(i) || wd[i] !== exp_d[i]) begin
                bad++; $display("FAIL gaps_write%0d want=%h/%h", i, 8'(i), exp_d[i]);
            end
        end
    endtask

    task automatic test_overflow();
        int acc;
        do_reset();
        pulse_start();
        for (int i = 0; i < 4; i++) send_word(16'hA000 + 16'(i), 1'b0, 0, 1'b1, acc);
        in_valid = 1'b1; in_data = 16'hEEEE;
        repeat (4) tick();
        in_valid = 1'b0;
        total++;
        if (wa4.size() !== 4) begin
            bad++; $display("FAIL ovf_write_count got=%0d want=4", wa4.size());
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (wa4.size() <= i || wa4[i] !== 2'(i) || wd4[i] !== 16'hA000 + 16'(i)) begin
                bad++; $display("FAIL ovf_write%0d want=%h/%h", i, 2'(i), 16'hA000 + 16'(i));
            end
        end
        total++;
        if ({error4, in_ready4, cpu_reset4, busy4, done4} !== 5'b10100 || word_count4 !== 3'd4) begin
            bad++; $display("FAIL ovf_flags got=%b/%0d want=10100/4", {error4, in_ready4, cpu_reset4, busy4, done4}, word_count4);
        end
        pulse_start();
        total++;
        if ({error4, in_ready4, cpu_reset4} !== 3'b011 || word_count4 !== 3'd0) begin
            bad++; $display("FAIL ovf_restart got=%b/%0d want=011/0", {error4, in_ready4, cpu_reset4}, word_count4);
        end
        clear_logs();
        send_word(16'h4321, 1'b1, 0, 1'b1, acc);
        tick();
        total++;
        if (wa4.size() !== 1 || wa4[0] !== 2'd0 || wd4[0] !== 16'h4321) begin
            bad++; $display("FAIL ovf_reload got=%0d writes want=1 write 0/4321", wa4.size());
        end
    endtask

    task automatic test_last_at_depth();
        int acc;
        int at;
        do_reset();
        pulse_start();
        for (int i = 0; i < 4; i++) send_word(16'hB000 + 16'(i), i == 3, 0, 1'b1, acc);
        wait_done(1'b1, at);
        total++;
        if (at < 0 || error4 !== 1'b0 || word_count4 !== 3'd4 || cpu_reset4 !== 1'b0) begin
            bad++; $display("FAIL last_at_depth got=%0d/%b/%0d/%b want=done/0/4/0", at, error4, word_count4, cpu_reset4);
        end
    endtask

    task automatic test_mid_reset();
        int acc;
        do_reset();
        pulse_start();
        send_word(16'h1111, 1'b0, 0, 1'b0, acc);
        send_word(16'h2222, 1'b0, 0, 1'b0, acc);
        rst_n = 1'b0; in_valid = 1'b1; in_data = 16'h3333;
        tick();
        total++;
        if (imem_we !== 1'b0 || word_count !== 9'd0) begin
            bad++; $display("FAIL midrst_state got=%b/%0d want=0/0", imem_we, word_count);
        end
        total++;
        if ({cpu_reset, busy, in_ready, done} !== 4'b1000) begin
            bad++; $display("FAIL midrst_flags got=%b want=1000", {cpu_reset, busy, in_ready, done});
        end
        rst_n = 1'b1;
        repeat (3) tick();
        in_valid = 1'b0;
        total++;
        if (wa.size() !== 2 || busy !== 1'b0) begin
            bad++; $display("FAIL midrst_no_write got=%0d writes want=2", wa.size());
        end
    endtask

    task automatic test_reload();
        int acc;
        int at;
        do_reset();
        pulse_start();
        send_word(16'h1111, 1'b1, 0, 1'b0, acc);
        wait_done(1'b0, at);
        total++;
        if (at < 0) begin
            bad++; $display("FAIL reload_first_done got=timeout want=done");
        end
        pulse_start();
        total++;
        if ({cpu_reset, done, busy, in_ready} !== 4'b1011 || word_count !== 9'd0) begin
            bad++; $display("FAIL reload_entry got=%b/%0d want=1011/0", {cpu_reset, done, busy, in_ready}, word_count);
        end
        clear_logs();
        send_word(16'h0BAD, 1'b0, 0, 1'b0, acc);
        start = 1'b1;
        send_word(16'h0F00, 1'b1, 0, 1'b0, acc);
        tick();
        start = 1'b0;
        wait_done(1'b0, at);
        total++;
        if (at < 0 || word_count !== 9'd2) begin
            bad++; $display("FAIL reload_start_ignored got=%0d/%0d want=done/2", at, word_count);
        end
        total++;
        if (wa.size() !== 2 || wa[0] !== 8'd0 || wd[0] !== 16'h0BAD || wa[1] !== 8'd1 || wd[1] !== 16'h0F00) begin
            bad++; $display("FAIL reload_writes got=%0d writes want=2 (0/0bad,1/0f00)", wa.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_overflow();
        test_last_at_depth();
        test_mid_reset();
        test_reload();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
